// File: rtl/time_unit_counter.sv
// Modulo-MODULO time-field counter with cascade tick, up/down buttons with
// hold-to-auto-repeat, synchronous load and registered carry/borrow pulses.
module time_unit_counter #(
  parameter int WIDTH         = 6,
  parameter int MODULO        = 24,
  parameter int RESET_VAL     = 0,
  parameter int HOLD_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 100
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             tick_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_o,
  output logic             borrow_o
);

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    REP_LAST  = TW'(REPEAT_CYCLES - 1);
  localparam logic [WIDTH:0]   MOD_X     = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] TOP_V     = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_V     = WIDTH'(RESET_VAL);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [TW-1:0]     timer_r, timer_nxt_s;
  logic              dir_up_r, dir_up_nxt_s;
  logic              step_up_s, step_dn_s;
  logic              own_s, opp_s;
  logic [TW-1:0]     last_s;

  logic [WIDTH:0]    sum_s;
  logic              load_ok_s;
  logic [WIDTH-1:0]  val_nxt_s;
  logic              carry_nxt_s, borrow_nxt_s;

  // Button FSM next-state decode; a step is issued on the edge that samples it.
  always_comb begin
    state_nxt_s  = state_r;
    timer_nxt_s  = timer_r;
    dir_up_nxt_s = dir_up_r;
    step_up_s    = 1'b0;
    step_dn_s    = 1'b0;
    own_s        = dir_up_r ? inc_i : dec_i;
    opp_s        = dir_up_r ? dec_i : inc_i;
    last_s       = (state_r == HOLD) ? HOLD_LAST : REP_LAST;
    case (state_r)
      IDLE: begin
        if (inc_i ^ dec_i) begin
          step_up_s    = inc_i;
          step_dn_s    = dec_i;
          dir_up_nxt_s = inc_i;
          timer_nxt_s  = '0;
          state_nxt_s  = HOLD;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      HOLD, REPEAT: begin
        if (!own_s) begin
          timer_nxt_s = '0;
          state_nxt_s = IDLE;
        end else if (opp_s) begin
          timer_nxt_s = '0;
          state_nxt_s = WAIT_REL;
        end else if (timer_r == last_s) begin
          step_up_s   = dir_up_r;
          step_dn_s   = !dir_up_r;
          timer_nxt_s = '0;
          state_nxt_s = REPEAT;
        end else begin
          timer_nxt_s = timer_r + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!inc_i && !dec_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_REL;
        end
      end
      default: begin
        timer_nxt_s = '0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Value datapath: valid load wins, then net step of tick + up - down.
  always_comb begin
    val_nxt_s    = value_o;
    carry_nxt_s  = 1'b0;
    borrow_nxt_s = 1'b0;
    sum_s        = {1'b0, value_o} + {{WIDTH{1'b0}}, tick_i} + {{WIDTH{1'b0}}, step_up_s};
    load_ok_s    = load_i && ({1'b0, load_val_i} < MOD_X);
    if (load_ok_s) begin
      val_nxt_s = load_val_i;
    end else if (step_dn_s) begin
      // A tick cancels a down step; only a bare down step moves the value.
      if (tick_i) begin
        val_nxt_s = value_o;
      end else if (value_o == '0) begin
        val_nxt_s    = TOP_V;
        borrow_nxt_s = 1'b1;
      end else begin
        val_nxt_s = value_o - 1'b1;
      end
    end else if (tick_i || step_up_s) begin
      if (sum_s >= MOD_X) begin
        val_nxt_s   = WIDTH'(sum_s - MOD_X);
        carry_nxt_s = 1'b1;
      end else begin
        val_nxt_s   = sum_s[WIDTH-1:0];
      end
    end else begin
      val_nxt_s = value_o;
    end
  end

  // State, timer, direction and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r  <= IDLE;
      timer_r  <= '0;
      dir_up_r <= 1'b1;
      value_o  <= RST_V;
      carry_o  <= 1'b0;
      borrow_o <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      timer_r  <= timer_nxt_s;
      dir_up_r <= dir_up_nxt_s;
      value_o  <= val_nxt_s;
      carry_o  <= carry_nxt_s;
      borrow_o <= borrow_nxt_s;
    end
  end

endmodule

// File: tb/tb_time_unit_counter.sv
// Self-checking bench for time_unit_counter: directed scenarios plus random
// stimulus compared against a press-duration reference model.
module tb_time_unit_counter;

  localparam int W = 5;
  localparam int M = 24;
  localparam int H = 4;
  localparam int R = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         tick, inc, dec, load;
  logic [W-1:0] lv;
  logic [W-1:0] value;
  logic         carry, borrow;

  int tests = 0;
  int fails = 0;

  // Reference model: value plus how long the current press has lasted.
  int m_v;
  int m_dir;
  int m_held;
  bit m_lock;
  int m_carry, m_borrow;

  time_unit_counter #(
    .WIDTH(W), .MODULO(M), .RESET_VAL(0), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .tick_i(tick), .inc_i(inc), .dec_i(dec),
    .load_i(load), .load_val_i(lv), .value_o(value), .carry_o(carry), .borrow_o(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_dir = 0; m_held = 0; m_lock = 0; m_carry = 0; m_borrow = 0;
  endtask

  task automatic model_step(input bit t, input bit i, input bit d, input bit l, input int lval);
    int up, dn, s;
    bit own, opp;
    up = 0; dn = 0;
    if (m_lock) begin
      if (!i && !d) m_lock = 0;
    end else if (m_dir == 0) begin
      if (i != d) begin
        m_dir  = i ? 1 : -1;
        m_held = 1;
        if (i) up = 1; else dn = 1;
      end
    end else begin
      own = (m_dir > 0) ? i : d;
      opp = (m_dir > 0) ? d : i;
      if (!own) m_dir = 0;
      else if (opp) begin m_dir = 0; m_lock = 1; end
      else begin
        m_held++;
        if (m_held == 1 + H || (m_held > 1 + H && (m_held - 1 - H) % R == 0)) begin
          if (m_dir > 0) up = 1; else dn = 1;
        end
      end
    end
    m_carry = 0; m_borrow = 0;
    if (l && lval < M) m_v = lval;
    else begin
      s = m_v + int'(t) + up - dn;
      if (s >= M) begin s -= M; m_carry = 1; end
      else if (s < 0) begin s += M; m_borrow = 1; end
      m_v = s;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".value"},  32'(value),  32'(m_v));
    chk({tag, ".carry"},  32'(carry),  32'(m_carry));
    chk({tag, ".borrow"}, 32'(borrow), 32'(m_borrow));
  endtask

  task automatic cyc(input bit t, input bit i, input bit d, input bit l, input int lval, input string tag);
    logic [31:0] lv32;
    lv32 = 32'(lval);
    tick = t; inc = i; dec = d; load = l; lv = lv32[W-1:0];
    @(posedge clk);
    model_step(t, i, d, l, lval);
    #1;
    check_model(tag);
  endtask

  // Called just after an edge; asserts reset between edges and releases it
  // before the next edge with inputs left as they are.
  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_value"},  32'(value),  32'd0);
    chk({tag, ".rst_carry"},  32'(carry),  32'd0);
    chk({tag, ".rst_borrow"}, 32'(borrow), 32'd0);
    #3 rstn = 1'b1;
  endtask

  initial begin
    int ncarry, nborrow, run, pat;
    bit pi, pd;
    rstn = 1'b0; tick = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; lv = '0;
    model_reset();
    #12;
    chk("reset.value", 32'(value), 32'd0);
    chk("reset.carry", 32'(carry), 32'd0);
    chk("reset.borrow", 32'(borrow), 32'd0);
    #1 rstn = 1'b1;

    // Cascade ticks through a full wrap.
    ncarry = 0; nborrow = 0;
    for (int k = 0; k < M; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, "tick");
      ncarry += int'(carry); nborrow += int'(borrow);
    end
    chk("tick.final", 32'(value), 32'd0);
    chk("tick.ncarry", 32'(ncarry), 32'd1);
    chk("tick.nborrow", 32'(nborrow), 32'd0);

    // Hold inc for 10 edges: steps at edges 1, 5, 7, 9.
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, "hold_inc");
    chk("hold_inc.final", 32'(value), 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, "release");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, "dec_press");
    chk("dec_press.final", 32'(value), 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, "release");

    // Wrap boundaries.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, "load0");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, "borrow_wrap");
    chk("borrow_wrap.value", 32'(value), 32'd23);
    chk("borrow_wrap.borrow", 32'(borrow), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, "borrow_gone");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 22, "load22");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "plus2_from22");
    chk("plus2_from22.value", 32'(value), 32'd0);
    chk("plus2_from22.carry", 32'(carry), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 23, "load23");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, "plus2_from23");
    chk("plus2_from23.value", 32'(value), 32'd1);
    chk("plus2_from23.carry", 32'(carry), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, "release");

    // Loads: valid, out of range, and load overriding a wrapping tick.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 17, "load17");
    chk("load17.value", 32'(value), 32'd17);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 30, "load30");
    chk("load30.value", 32'(value), 32'd17);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 23, "load23b");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 17, "load_tick");
    chk("load_tick.value", 32'(value), 32'd17);
    chk("load_tick.carry", 32'(carry), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, "tick_plus_down");

    // Opposite button lockout until both released.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 10, "load10");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, "lock_press");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, "lock_hold");
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, "lock_both");
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, "lock_wait");
    chk("lock.value", 32'(value), 32'd11);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, "lock_release");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, "lock_dec");
    chk("lock_dec.value", 32'(value), 32'd10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, "release");

    // Async reset during auto-repeat, button still held afterwards.
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, "repeat_inc");
    async_reset("mid_repeat");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, "post_reset");
    chk("post_reset.value", 32'(value), 32'd1);

    // Random button runs, ticks, loads and occasional resets.
    run = 0; pi = 1'b0; pd = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (run == 0) begin
        pat = $urandom_range(0, 9);
        pi  = (pat == 4 || pat == 5 || pat == 8);
        pd  = (pat == 6 || pat == 7 || pat == 8);
        run = $urandom_range(1, 12);
      end
      run--;
      cyc($urandom_range(0, 3) == 0, pi, pd, $urandom_range(0, 15) == 0,
          int'($urandom_range(0, 31)), "rand");
      if ($urandom_range(0, 299) == 0) async_reset("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
